// File: rtl/qs_srt_range_sched_pkg.sv
// Shared types for the qs_srt quicksort range scheduler: range word, FSM states
// and the range liveness rule.
package qs_pkg;

    localparam int QS_AW = 16;

    // Packed so a range maps directly onto the stack word {hi,lo}.
    typedef struct packed {
        logic [QS_AW-1:0] hi;
        logic [QS_AW-1:0] lo;
    } range_t;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_RSP,
        ST_SPLIT,
        ST_POP,
        ST_POP_W1,
        ST_POP_W2,
        ST_DONE,
        ST_ERR
    } range_sched_state_t;

    // A range needs partitioning only if it holds at least two elements.
    function automatic logic range_live(input logic [QS_AW-1:0] lo, input logic [QS_AW-1:0] hi);
        return hi > lo;
    endfunction

endpackage

// File: rtl/qs_srt_range_sched_split.sv
// Combinational split of a partitioned range around its final pivot into the
// left and right sub-ranges, with their liveness.
module qs_srt_range_split
    import qs_pkg::*;
(
    input  range_t           cur,
    input  logic [QS_AW-1:0] pivot,
    output logic             l_live,
    output logic             r_live,
    output range_t           l_rng,
    output range_t           r_rng
);

    always_comb begin
        l_rng.lo = cur.lo;
        l_rng.hi = pivot - QS_AW'(1);
        r_rng.lo = pivot + QS_AW'(1);
        r_rng.hi = cur.hi;
        // The outer compare guards the +/-1 so neither bound can wrap.
        l_live   = (pivot > cur.lo) && range_live(cur.lo, l_rng.hi);
        r_live   = (cur.hi > pivot) && range_live(r_rng.lo, cur.hi);
    end

endmodule

// File: rtl/qs_srt_range_sched.sv
// Quicksort range scheduler: issues ranges to the partition engine, defers one
// sub-range per split onto the range stack and recovers deferred ranges by pop.
module qs_srt_range_sched
    import qs_pkg::*;
#(
    parameter int N  = 16,
    parameter int AW = QS_AW
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_vld,
    input  logic [AW:0]     start_n,
    output logic            start_rdy,
    output logic            part_req_vld,
    output logic [AW-1:0]   part_req_lo,
    output logic [AW-1:0]   part_req_hi,
    input  logic            part_req_rdy,
    input  logic            part_rsp_vld,
    input  logic [AW-1:0]   part_rsp_pivot,
    output logic            stk_cmd_vld,
    output logic            stk_cmd_push,
    output logic [2*AW-1:0] stk_cmd_push_dat,
    output logic            stk_cmd_clr,
    input  logic [2*AW-1:0] stk_head_r,
    input  logic            stk_cmd_err_w,
    input  logic            stk_empty_w,
    input  logic            stk_full_w,
    output logic            busy_r,
    output logic            done_r,
    output logic            err_r
);

    localparam int DW = $clog2(N + 1);

    range_sched_state_t state_q, state_d;
    range_t             cur_q, cur_d;
    logic [AW-1:0]      pivot_q, pivot_d;
    logic [DW-1:0]      depth_q, depth_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic               stk_full;

    logic   l_live, r_live;
    range_t l_rng, r_rng;

    qs_srt_range_split u_split (
        .cur    (cur_q),
        .pivot  (pivot_q),
        .l_live (l_live),
        .r_live (r_live),
        .l_rng  (l_rng),
        .r_rng  (r_rng)
    );

    always_comb begin
        state_d          = state_q;
        cur_d            = cur_q;
        pivot_d          = pivot_q;
        depth_d          = depth_q;
        err_d            = err_q;
        start_rdy        = 1'b0;
        part_req_vld     = 1'b0;
        part_req_lo      = '0;
        part_req_hi      = '0;
        stk_cmd_vld      = 1'b0;
        stk_cmd_push     = 1'b0;
        stk_cmd_push_dat = '0;
        stk_cmd_clr      = 1'b0;
        // Local occupancy count backs up the stack's own full flag.
        stk_full         = stk_full_w || (depth_q == DW'(N));

        case (state_q)
            ST_IDLE: begin
                start_rdy = 1'b1;
                if (start_vld) begin
                    stk_cmd_clr = 1'b1;
                    err_d       = 1'b0;
                    depth_d     = '0;
                    cur_d.lo    = '0;
                    cur_d.hi    = QS_AW'(start_n - (AW+1)'(1));
                    state_d     = (start_n <= (AW+1)'(1)) ? ST_DONE : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                part_req_vld = 1'b1;
                part_req_lo  = cur_q.lo;
                part_req_hi  = cur_q.hi;
                if (part_req_rdy) state_d = ST_WAIT_RSP;
            end
            ST_WAIT_RSP: begin
                if (part_rsp_vld) begin
                    pivot_d = part_rsp_pivot;
                    if (part_rsp_pivot < cur_q.lo || part_rsp_pivot > cur_q.hi) state_d = ST_ERR;
                    else state_d = ST_SPLIT;
                end
            end
            ST_SPLIT: begin
                if (l_live && r_live) begin
                    if (stk_full) begin
                        state_d = ST_ERR;
                    end else begin
                        stk_cmd_vld      = 1'b1;
                        stk_cmd_push     = 1'b1;
                        stk_cmd_push_dat = r_rng;
                        if (stk_cmd_err_w) begin
                            state_d = ST_ERR;
                        end else begin
                            cur_d   = l_rng;
                            depth_d = depth_q + DW'(1);
                            state_d = ST_ISSUE;
                        end
                    end
                end else if (l_live) begin
                    cur_d   = l_rng;
                    state_d = ST_ISSUE;
                end else if (r_live) begin
                    cur_d   = r_rng;
                    state_d = ST_ISSUE;
                end else if (stk_empty_w) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_POP;
                end
            end
            ST_POP: begin
                stk_cmd_vld = 1'b1;
                if (stk_cmd_err_w) begin
                    state_d = ST_ERR;
                end else begin
                    depth_d = depth_q - DW'(1);
                    state_d = ST_POP_W1;
                end
            end
            ST_POP_W1: state_d = ST_POP_W2;
            ST_POP_W2: begin
                cur_d   = range_t'(stk_head_r);
                state_d = ST_ISSUE;
            end
            ST_DONE:   state_d = ST_IDLE;
            ST_ERR:    state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
        if (state_d == ST_ERR) err_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cur_q   <= '0;
            pivot_q <= '0;
            depth_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            pivot_q <= pivot_d;
            depth_q <= depth_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign busy_r = busy_q;
    assign done_r = done_q;
    assign err_r  = err_q;

endmodule
